// File: rtl/wiener_pkg.sv
// Shared definitions for the Wiener coefficient loader: parser states,
// packet framing constants and error codes.
package wiener_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_LOAD,
    ST_CSUM,
    ST_DONE,
    ST_ERR
  } state_t;

  localparam logic [15:0] HEADER = 16'hC7E5;

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_CSUM  = 2'd1;
  localparam logic [1:0] ERR_TMO   = 2'd2;
  localparam logic [1:0] ERR_ABORT = 2'd3;

  // Bit positions inside the endpoint/command word.
  localparam int CMD_RSVD = 0;
  localparam int CMD_HOLD = 1;

  function automatic logic [15:0] swap_bytes(input logic [15:0] w);
    return {w[7:0], w[15:8]};
  endfunction

endpackage

// File: rtl/coef_stream_timeout.sv
// Saturating idle-cycle counter; flags the idle cycle that reaches LIMIT
// so the parser can abandon a stalled packet on that same edge.
module coef_stream_timeout #(
  parameter int LIMIT = 65535
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic i_enable,
  input  logic i_clear,
  output logic o_expired
);

  localparam int CW = $clog2(LIMIT + 1);

  logic [CW-1:0] r_count;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (i_clear || !i_enable) begin
      r_count <= '0;
    end else if (r_count != CW'(LIMIT)) begin
      r_count <= r_count + 1'b1;
    end
  end

  // r_count holds completed idle cycles; the current idle cycle is the next one.
  assign o_expired = i_enable && !i_clear && (r_count >= CW'(LIMIT - 1));

endmodule

// File: rtl/rec_coef_loader.sv
// Host-stream coefficient loader: parses header/command/payload/checksum and
// fills the shadow bank of a ping-pong RAM, swapping banks only on a good table.
module rec_coef_loader #(
  parameter int                DATA_W      = 16,
  parameter int                NUM_WORDS   = 256,
  parameter int                ADDR_W      = 8,
  parameter logic [DATA_W-1:0] HEADER      = wiener_pkg::HEADER,
  parameter int                BYTE_SWAP   = 1,
  parameter int                TIMEOUT_CYC = 65535
) (
  input  logic              clk_in,
  input  logic              rst_n,
  input  logic              data_valid,
  input  logic [DATA_W-1:0] din,
  input  logic [7:0]        ep_addr,
  input  logic              abort,
  output logic [DATA_W-1:0] wr_ram_data,
  output logic              wr_ram_en,
  output logic [ADDR_W-1:0] wr_ram_addr,
  output logic              wr_ram_bank,
  output logic              active_bank,
  output logic              load_busy,
  output logic              load_done,
  output logic              load_err,
  output logic [1:0]        err_code
);

  import wiener_pkg::*;

  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W + 1)'(NUM_WORDS - 1);

  state_t            r_state;
  logic [ADDR_W:0]   r_cnt;
  logic [DATA_W-1:0] r_sum;
  logic              r_hold;
  logic [DATA_W-1:0] r_wr_data;
  logic [ADDR_W-1:0] r_wr_addr;
  logic              r_wr_en;
  logic              r_active_bank;
  logic              r_busy;
  logic              r_done;
  logic              r_err;
  logic [1:0]        r_err_code;

  logic [DATA_W-1:0] w_word;
  logic              w_ep_match;
  logic              w_tmo_en;
  logic              w_tmo_expired;
  logic              w_fail;
  logic [1:0]        w_fail_code;

  generate
    if (BYTE_SWAP != 0 && DATA_W == 16) begin : g_swap
      assign w_word = swap_bytes(din);
    end else begin : g_noswap
      assign w_word = din;
    end
  endgenerate

  assign w_ep_match = (w_word[15:8] == ep_addr);
  assign w_tmo_en   = (r_state == ST_ADDR) || (r_state == ST_LOAD) || (r_state == ST_CSUM);

  coef_stream_timeout #(
    .LIMIT(TIMEOUT_CYC)
  ) u_timeout (
    .clk_in   (clk_in),
    .rst_n    (rst_n),
    .i_enable (w_tmo_en),
    .i_clear  (data_valid),
    .o_expired(w_tmo_expired)
  );

  // Abort outranks both an accepted word and a timeout in the same cycle.
  assign w_fail      = w_tmo_en && (abort || w_tmo_expired);
  assign w_fail_code = abort ? ERR_ABORT : ERR_TMO;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_sum         <= '0;
      r_hold        <= 1'b0;
      r_wr_data     <= '0;
      r_wr_addr     <= '0;
      r_wr_en       <= 1'b0;
      r_active_bank <= 1'b0;
      r_busy        <= 1'b0;
      r_done        <= 1'b0;
      r_err         <= 1'b0;
      r_err_code    <= ERR_NONE;
    end else begin
      r_wr_en <= 1'b0;
      r_done  <= 1'b0;
      r_err   <= 1'b0;
      if (w_fail) begin
        r_state    <= ST_ERR;
        r_err      <= 1'b1;
        r_err_code <= w_fail_code;
      end else begin
        case (r_state)
          ST_IDLE: begin
            if (data_valid && (w_word == HEADER)) begin
              r_state    <= ST_ADDR;
              r_busy     <= 1'b1;
              r_err_code <= ERR_NONE;
            end
          end
          ST_ADDR: begin
            if (data_valid) begin
              if (w_ep_match && !w_word[CMD_RSVD]) begin
                r_state <= ST_LOAD;
                r_cnt   <= '0;
                r_sum   <= '0;
                r_hold  <= w_word[CMD_HOLD];
              end else begin
                r_state <= ST_IDLE;
                r_busy  <= 1'b0;
              end
            end
          end
          ST_LOAD: begin
            if (data_valid) begin
              r_wr_en   <= 1'b1;
              r_wr_addr <= r_cnt[ADDR_W-1:0];
              r_wr_data <= w_word;
              r_sum     <= r_sum + w_word;
              r_cnt     <= r_cnt + 1'b1;
              if (r_cnt == LAST_IDX) begin
                r_state <= ST_CSUM;
              end
            end
          end
          ST_CSUM: begin
            if (data_valid) begin
              if (w_word == r_sum) begin
                r_state <= ST_DONE;
                r_done  <= 1'b1;
                if (!r_hold) begin
                  r_active_bank <= ~r_active_bank;
                end
              end else begin
                r_state    <= ST_ERR;
                r_err      <= 1'b1;
                r_err_code <= ERR_CSUM;
              end
            end
          end
          default: begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign wr_ram_data = r_wr_data;
  assign wr_ram_en   = r_wr_en;
  assign wr_ram_addr = r_wr_addr;
  assign wr_ram_bank = ~r_active_bank;
  assign active_bank = r_active_bank;
  assign load_busy   = r_busy;
  assign load_done   = r_done;
  assign load_err    = r_err;
  assign err_code    = r_err_code;

endmodule

// File: tb/tb_rec_coef_loader.sv
// Randomised bench for rec_coef_loader against a packet-level reference model
// (expected writes, outcome and bank state derived from the packet contents).
module tb_rec_coef_loader;

  localparam int          NUM_WORDS = 4;
  localparam int          ADDR_W    = 2;
  localparam int          TMO       = 10;
  localparam logic [15:0] HDR       = 16'hC7E5;

  logic        clk_in = 1'b0;
  logic        rst_n = 1'b0;
  logic        data_valid = 1'b0;
  logic        abort = 1'b0;
  logic [15:0] din = 16'h0;
  logic [7:0]  ep_addr = 8'h12;

  logic [15:0]       wr_ram_data;
  logic              wr_ram_en;
  logic [ADDR_W-1:0] wr_ram_addr;
  logic              wr_ram_bank;
  logic              active_bank;
  logic              load_busy;
  logic              load_done;
  logic              load_err;
  logic [1:0]        err_code;

  rec_coef_loader #(
    .DATA_W(16), .NUM_WORDS(NUM_WORDS), .ADDR_W(ADDR_W),
    .HEADER(HDR), .BYTE_SWAP(1), .TIMEOUT_CYC(TMO)
  ) dut (
    .clk_in(clk_in), .rst_n(rst_n), .data_valid(data_valid), .din(din),
    .ep_addr(ep_addr), .abort(abort), .wr_ram_data(wr_ram_data),
    .wr_ram_en(wr_ram_en), .wr_ram_addr(wr_ram_addr), .wr_ram_bank(wr_ram_bank),
    .active_bank(active_bank), .load_busy(load_busy), .load_done(load_done),
    .load_err(load_err), .err_code(err_code)
  );

  always #5 clk_in = ~clk_in;

  typedef struct packed {
    logic              bank;
    logic [ADDR_W-1:0] addr;
    logic [15:0]       data;
  } wr_t;

  wr_t         wrQ[$];
  wr_t         expQ[$];
  logic [15:0] pktQ[$];
  logic [15:0] pay[NUM_WORDS];
  logic        modelBank = 1'b0;
  int          doneCnt = 0;
  int          errCnt = 0;
  int          cyc = 0;
  int          checks = 0;
  int          passes = 0;
  bit          ok;
  int          bi;

  always @(posedge clk_in) cyc <= cyc + 1;

  // Observe the RAM port and status pulses mid-cycle.
  always @(negedge clk_in) begin
    if (wr_ram_en) wrQ.push_back({wr_ram_bank, wr_ram_addr, wr_ram_data});
    if (load_done) doneCnt++;
    if (load_err) errCnt++;
  end

  function automatic logic [15:0] swapW(input logic [15:0] w);
    return {w[7:0], w[15:8]};
  endfunction

  task automatic sendWord(input logic [15:0] w);
    din = swapW(w);
    data_valid = 1'b1;
    @(posedge clk_in); #1;
    data_valid = 1'b0;
    din = 16'($urandom);
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin @(posedge clk_in); #1; end
  endtask

  task automatic sendPkt(input int gapMax);
    foreach (pktQ[i]) begin
      sendWord(pktQ[i]);
      if (gapMax > 0) idleCycles($urandom_range(0, gapMax));
    end
  endtask

  task automatic randPay();
    foreach (pay[i]) pay[i] = 16'($urandom);
  endtask

  // Packet model: checksum is the plain 16-bit sum of the payload.
  task automatic makePkt(input logic [15:0] cmd, input bit bad);
    int s;
    s = 0;
    pktQ.delete();
    pktQ.push_back(HDR);
    pktQ.push_back(cmd);
    foreach (pay[i]) begin
      pktQ.push_back(pay[i]);
      s += int'(pay[i]);
    end
    if (bad) s += int'($urandom_range(1, 100));
    pktQ.push_back(16'(s));
  endtask

  task automatic buildExp(input logic bank);
    expQ.delete();
    foreach (pay[i]) expQ.push_back({bank, ADDR_W'(i), pay[i]});
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk_in);
    #1;
    checks++;
    if ({wr_ram_en, wr_ram_addr, wr_ram_data, active_bank, load_busy, load_done, load_err, err_code} !== '0)
      $display("[TB] FAIL reset_outputs: got en=%b addr=%h data=%h bank=%b busy=%b done=%b err=%b code=%0d, required all 0",
               wr_ram_en, wr_ram_addr, wr_ram_data, active_bank, load_busy, load_done, load_err, err_code);
    else passes++;
    checks++;
    if (wr_ram_bank !== 1'b1) $display("[TB] FAIL reset_wr_bank: got %b, required 1", wr_ram_bank);
    else passes++;
    rst_n = 1'b1;
    idleCycles(2);
  endtask

  task automatic test_good_packet();
    int d0, e0;
    pay = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    makePkt(16'h1200, 1'b0);
    buildExp(~modelBank);
    d0 = doneCnt; e0 = errCnt; wrQ.delete();
    sendWord(pktQ[0]);
    checks++;
    if (load_busy !== 1'b1) $display("[TB] FAIL busy_after_header: got %b, required 1", load_busy);
    else passes++;
    sendWord(pktQ[1]);
    sendWord(pktQ[2]);
    checks++;
    if ({wr_ram_en, wr_ram_addr, wr_ram_data} !== {1'b1, 2'd0, 16'h0001})
      $display("[TB] FAIL first_write_latency: got en=%b addr=%0d data=%h, required en=1 addr=0 data=0001",
               wr_ram_en, wr_ram_addr, wr_ram_data);
    else passes++;
    for (int i = 3; i < pktQ.size(); i++) sendWord(pktQ[i]);
    modelBank = ~modelBank;
    checks++;
    if ({load_done, active_bank, wr_ram_bank} !== {1'b1, modelBank, ~modelBank})
      $display("[TB] FAIL done_pulse_swap: got done=%b bank=%b wrbank=%b, required done=1 bank=%b wrbank=%b",
               load_done, active_bank, wr_ram_bank, modelBank, ~modelBank);
    else passes++;
    idleCycles(2);
    checks++;
    ok = (wrQ.size() == expQ.size()); bi = -1;
    foreach (expQ[i]) if (ok && wrQ[i] !== expQ[i]) begin ok = 0; bi = i; end
    if (ok) passes++;
    else $display("[TB] FAIL good_writes: got %0d writes, required %0d (first bad entry %0d)", wrQ.size(), expQ.size(), bi);
    checks++;
    if ({load_done, load_busy, err_code} !== 4'b0 || (doneCnt - d0) != 1 || (errCnt - e0) != 0)
      $display("[TB] FAIL good_status: got done=%b busy=%b code=%0d dones=%0d errs=%0d, required 0/0/0 dones=1 errs=0",
               load_done, load_busy, err_code, doneCnt - d0, errCnt - e0);
    else passes++;
  endtask

  task automatic test_bad_checksum();
    int d0, e0;
    pay = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    makePkt(16'h1200, 1'b0);
    pktQ[pktQ.size() - 1] = 16'h000B;
    buildExp(~modelBank);
    d0 = doneCnt; e0 = errCnt; wrQ.delete();
    sendPkt(0);
    idleCycles(2);
    checks++;
    ok = (wrQ.size() == expQ.size()); bi = -1;
    foreach (expQ[i]) if (ok && wrQ[i] !== expQ[i]) begin ok = 0; bi = i; end
    if (ok) passes++;
    else $display("[TB] FAIL csum_writes: got %0d writes, required %0d (first bad entry %0d)", wrQ.size(), expQ.size(), bi);
    checks++;
    if (err_code !== 2'd1 || active_bank !== modelBank || (doneCnt - d0) != 0 || (errCnt - e0) != 1)
      $display("[TB] FAIL csum_status: got code=%0d bank=%b dones=%0d errs=%0d, required code=1 bank=%b dones=0 errs=1",
               err_code, active_bank, doneCnt - d0, errCnt - e0, modelBank);
    else passes++;
  endtask

  task automatic test_hold();
    int d0;
    randPay();
    makePkt(16'h1202, 1'b0);
    buildExp(~modelBank);
    d0 = doneCnt; wrQ.delete();
    sendPkt(1);
    idleCycles(2);
    checks++;
    ok = (wrQ.size() == expQ.size()); bi = -1;
    foreach (expQ[i]) if (ok && wrQ[i] !== expQ[i]) begin ok = 0; bi = i; end
    if (ok) passes++;
    else $display("[TB] FAIL hold_writes: got %0d writes, required %0d (first bad entry %0d)", wrQ.size(), expQ.size(), bi);
    checks++;
    if (active_bank !== modelBank || (doneCnt - d0) != 1)
      $display("[TB] FAIL hold_no_swap: got bank=%b dones=%0d, required bank=%b dones=1", active_bank, doneCnt - d0, modelBank);
    else passes++;
    randPay();
    makePkt(16'h1200, 1'b0);
    buildExp(~modelBank);
    wrQ.delete();
    sendPkt(1);
    idleCycles(2);
    modelBank = ~modelBank;
    checks++;
    ok = (wrQ.size() == expQ.size()); bi = -1;
    foreach (expQ[i]) if (ok && wrQ[i] !== expQ[i]) begin ok = 0; bi = i; end
    if (ok) passes++;
    else $display("[TB] FAIL after_hold_writes: got %0d writes, required %0d (first bad entry %0d)", wrQ.size(), expQ.size(), bi);
    checks++;
    if (active_bank !== modelBank) $display("[TB] FAIL after_hold_swap: got bank=%b, required %b", active_bank, modelBank);
    else passes++;
  endtask

  task automatic test_wrong_ep();
    int d0, e0;
    pay = '{16'h0001, 16'h0002, 16'h0003, 16'h0004};
    d0 = doneCnt; e0 = errCnt; wrQ.delete();
    makePkt(16'h3400, 1'b0);
    sendPkt(0);
    makePkt(16'h1201, 1'b0);
    sendPkt(0);
    idleCycles(2);
    checks++;
    if (wrQ.size() != 0 || (doneCnt - d0) != 0 || (errCnt - e0) != 0 || load_busy !== 1'b0 || err_code !== 2'd0)
      $display("[TB] FAIL ignored_packets: got writes=%0d dones=%0d errs=%0d busy=%b code=%0d, required all 0",
               wrQ.size(), doneCnt - d0, errCnt - e0, load_busy, err_code);
    else passes++;
    randPay();
    makePkt(16'h1200, 1'b0);
    buildExp(~modelBank);
    wrQ.delete();
    sendPkt(2);
    idleCycles(2);
    modelBank = ~modelBank;
    checks++;
    ok = (wrQ.size() == expQ.size()); bi = -1;
    foreach (expQ[i]) if (ok && wrQ[i] !== expQ[i]) begin ok = 0; bi = i; end
    if (ok && active_bank === modelBank && (doneCnt - d0) == 1) passes++;
    else $display("[TB] FAIL accept_after_wrong_ep: got writes=%0d bank=%b dones=%0d, required writes=%0d bank=%b dones=1",
                  wrQ.size(), active_bank, doneCnt - d0, expQ.size(), modelBank);
  endtask

  task automatic test_timeout();
    int e0, lastCyc, gotCyc;
    bit found;
    randPay();
    makePkt(16'h1200, 1'b0);
    buildExp(~modelBank);
    expQ = expQ[0:1];
    e0 = errCnt; wrQ.delete();
    for (int i = 0; i < 4; i++) sendWord(pktQ[i]);
    lastCyc = cyc;
    found = 0; gotCyc = 0;
    for (int k = 0; k < 3 * TMO && !found; k++) begin
      @(negedge clk_in);
      if (load_err) begin found = 1; gotCyc = cyc; end
    end
    @(posedge clk_in); #1;
    checks++;
    if (!found) $display("[TB] FAIL timeout_wait: got no load_err within %0d cycles, required one", 3 * TMO);
    else if (gotCyc - lastCyc != TMO)
      $display("[TB] FAIL timeout_latency: got load_err %0d cycles after last word, required %0d", gotCyc - lastCyc, TMO);
    else passes++;
    idleCycles(2);
    checks++;
    ok = (wrQ.size() == expQ.size()); bi = -1;
    foreach (expQ[i]) if (ok && wrQ[i] !== expQ[i]) begin ok = 0; bi = i; end
    if (ok) passes++;
    else $display("[TB] FAIL timeout_writes: got %0d writes, required %0d (first bad entry %0d)", wrQ.size(), expQ.size(), bi);
    checks++;
    if (err_code !== 2'd2 || active_bank !== modelBank || load_busy !== 1'b0 || (errCnt - e0) != 1)
      $display("[TB] FAIL timeout_status: got code=%0d bank=%b busy=%b errs=%0d, required code=2 bank=%b busy=0 errs=1",
               err_code, active_bank, load_busy, errCnt - e0, modelBank);
    else passes++;
  endtask

  task automatic test_abort();
    int e0, d0;
    randPay();
    makePkt(16'h1200, 1'b0);
    buildExp(~modelBank);
    expQ = expQ[0:1];
    e0 = errCnt; d0 = doneCnt; wrQ.delete();
    for (int i = 0; i < 4; i++) sendWord(pktQ[i]);
    din = swapW(pktQ[4]);
    data_valid = 1'b1;
    abort = 1'b1;
    @(posedge clk_in); #1;
    data_valid = 1'b0;
    abort = 1'b0;
    checks++;
    if ({load_err, err_code, wr_ram_en} !== {1'b1, 2'd3, 1'b0})
      $display("[TB] FAIL abort_response: got err=%b code=%0d en=%b, required err=1 code=3 en=0", load_err, err_code, wr_ram_en);
    else passes++;
    idleCycles(2);
    checks++;
    ok = (wrQ.size() == expQ.size()); bi = -1;
    foreach (expQ[i]) if (ok && wrQ[i] !== expQ[i]) begin ok = 0; bi = i; end
    if (ok) passes++;
    else $display("[TB] FAIL abort_writes: got %0d writes, required %0d (first bad entry %0d)", wrQ.size(), expQ.size(), bi);
    abort = 1'b1;
    idleCycles(1);
    abort = 1'b0;
    idleCycles(2);
    checks++;
    if (err_code !== 2'd3 || load_busy !== 1'b0 || active_bank !== modelBank || (errCnt - e0) != 1 || (doneCnt - d0) != 0)
      $display("[TB] FAIL abort_idle: got code=%0d busy=%b bank=%b errs=%0d dones=%0d, required code=3 busy=0 bank=%b errs=1 dones=0",
               err_code, load_busy, active_bank, errCnt - e0, doneCnt - d0, modelBank);
    else passes++;
  endtask

  task automatic test_back_to_back();
    int d0, e0;
    wr_t allExp[$];
    randPay();
    makePkt(16'h1200, 1'b1);
    buildExp(~modelBank);
    allExp = expQ;
    d0 = doneCnt; e0 = errCnt; wrQ.delete();
    sendPkt(0);
    idleCycles(1);
    randPay();
    makePkt(16'h1200, 1'b0);
    buildExp(~modelBank);
    allExp = {allExp, expQ};
    sendPkt(0);
    idleCycles(2);
    modelBank = ~modelBank;
    checks++;
    ok = (wrQ.size() == allExp.size()); bi = -1;
    foreach (allExp[i]) if (ok && wrQ[i] !== allExp[i]) begin ok = 0; bi = i; end
    if (ok) passes++;
    else $display("[TB] FAIL b2b_writes: got %0d writes, required %0d (first bad entry %0d)", wrQ.size(), allExp.size(), bi);
    checks++;
    if (active_bank !== modelBank || (doneCnt - d0) != 1 || (errCnt - e0) != 1 || err_code !== 2'd0)
      $display("[TB] FAIL b2b_status: got bank=%b dones=%0d errs=%0d code=%0d, required bank=%b dones=1 errs=1 code=0",
               active_bank, doneCnt - d0, errCnt - e0, err_code, modelBank);
    else passes++;
  endtask

  task automatic test_random_packets();
    int  d0, e0;
    bit  hold, bad;
    for (int it = 0; it < 6; it++) begin
      randPay();
      if (it == 2) pay[1] = HDR;
      hold = ($urandom_range(0, 3) == 0);
      bad  = ($urandom_range(0, 2) == 0);
      makePkt({8'h12, 6'h0, hold, 1'b0}, bad);
      buildExp(~modelBank);
      d0 = doneCnt; e0 = errCnt; wrQ.delete();
      sendPkt(3);
      idleCycles(2 + $urandom_range(0, 2));
      if (!bad && !hold) modelBank = ~modelBank;
      checks++;
      ok = (wrQ.size() == expQ.size()); bi = -1;
      foreach (expQ[i]) if (ok && wrQ[i] !== expQ[i]) begin ok = 0; bi = i; end
      if (ok) passes++;
      else $display("[TB] FAIL rand_writes[%0d]: got %0d writes, required %0d (first bad entry %0d)", it, wrQ.size(), expQ.size(), bi);
      checks++;
      if ((doneCnt - d0) != (bad ? 0 : 1) || (errCnt - e0) != (bad ? 1 : 0))
        $display("[TB] FAIL rand_outcome[%0d]: got dones=%0d errs=%0d, required dones=%0d errs=%0d",
                 it, doneCnt - d0, errCnt - e0, bad ? 0 : 1, bad ? 1 : 0);
      else passes++;
      checks++;
      if (active_bank !== modelBank) $display("[TB] FAIL rand_bank[%0d]: got %b, required %b", it, active_bank, modelBank);
      else passes++;
      checks++;
      if (err_code !== (bad ? 2'd1 : 2'd0)) $display("[TB] FAIL rand_code[%0d]: got %0d, required %0d", it, err_code, bad ? 1 : 0);
      else passes++;
    end
  endtask

  task automatic test_reset_mid_load();
    int d0;
    randPay();
    makePkt(16'h1200, 1'b0);
    for (int i = 0; i < 4; i++) sendWord(pktQ[i]);
    #2;
    rst_n = 1'b0;
    #1;
    modelBank = 1'b0;
    checks++;
    if ({wr_ram_en, wr_ram_addr, wr_ram_data, active_bank, load_busy, load_done, load_err, err_code} !== '0 || wr_ram_bank !== 1'b1)
      $display("[TB] FAIL async_reset: got en=%b addr=%h data=%h bank=%b wrbank=%b busy=%b code=%0d, required zeros with wrbank=1",
               wr_ram_en, wr_ram_addr, wr_ram_data, active_bank, wr_ram_bank, load_busy, err_code);
    else passes++;
    @(posedge clk_in); #1;
    rst_n = 1'b1;
    idleCycles(1);
    randPay();
    makePkt(16'h1200, 1'b0);
    buildExp(~modelBank);
    d0 = doneCnt; wrQ.delete();
    sendPkt(1);
    idleCycles(2);
    modelBank = ~modelBank;
    checks++;
    ok = (wrQ.size() == expQ.size()); bi = -1;
    foreach (expQ[i]) if (ok && wrQ[i] !== expQ[i]) begin ok = 0; bi = i; end
    if (ok && active_bank === modelBank && (doneCnt - d0) == 1) passes++;
    else $display("[TB] FAIL post_reset_packet: got writes=%0d bank=%b dones=%0d, required writes=%0d bank=%b dones=1",
                  wrQ.size(), active_bank, doneCnt - d0, expQ.size(), modelBank);
  endtask

  initial begin
    test_reset();
    test_good_packet();
    test_bad_checksum();
    test_hold();
    test_wrong_ep();
    test_timeout();
    test_abort();
    test_back_to_back();
    test_random_packets();
    test_reset_mid_load();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required completion", $time);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/rec_coef_loader.md
Name: rec_coef_loader

Overview:
- Parametrised successor to the single-bank Wiener parameter receiver.
- Parses the host word stream: header, then endpoint/command word, then NUM_WORDS coefficient words, then a checksum word.
- Writes coefficients into the shadow half of a ping-pong coefficient RAM and swaps banks only when the checksum matches. The decoder therefore never sees a partial or corrupt table.
- Sits between the host pipe receiver and the Wiener MAC coefficient RAM.

Parameters:
DATA_W, 16, stream and coefficient word width
NUM_WORDS, 256, coefficients per packet (2..2^ADDR_W)
ADDR_W, 8, RAM address width
HEADER, 16'hC7E5, packet start word after byte swap
BYTE_SWAP, 1, 1 = swap byte halves of din before parsing (DATA_W=16 only)
TIMEOUT_CYC, 65535, max idle cycles between payload words before abort

Ports:
clk_in  in  1  system clock
rst_n  in  1  reset, asynchronous assert, active-low
data_valid  in  1  din qualifier, one word per high cycle
din  in  DATA_W  raw stream word
ep_addr  in  8  this block's endpoint address
abort  in  1  synchronous cancel of any packet in flight
wr_ram_data  out  DATA_W  coefficient write data
wr_ram_en  out  1  RAM write strobe
wr_ram_addr  out  ADDR_W  coefficient index
wr_ram_bank  out  1  bank being written (= ~active_bank)
active_bank  out  1  bank the decoder reads
load_busy  out  1  high from header accept to DONE/ERR exit
load_done  out  1  one-cycle pulse on good packet
load_err  out  1  one-cycle pulse on failed packet
err_code  out  2  held until next header: 0 none, 1 checksum, 2 timeout, 3 abort

Behaviour:
- Reset values:
  - All outputs 0. active_bank=0, so wr_ram_bank=1.
  - Counters 0, state IDLE.
- w = BYTE_SWAP ? {din[7:0],din[15:8]} : din.
- Only data_valid cycles advance the parser.
- States:
  - IDLE: w==HEADER -> ADDR; load_busy=1; err_code=0. Any other word is ignored.
  - ADDR:
    - w[15:8]!=ep_addr -> IDLE silently, no error.
    - w[15:8]==ep_addr and w[0]==0 -> LOAD, cnt=0, sum=0, latch hold=w[1].
    - w[0]==1 (reserved) -> IDLE silently.
  - LOAD: each word:
    - wr_ram_en=1 next cycle; wr_ram_addr=cnt; wr_ram_data=w.
    - sum += w, mod 2^DATA_W.
    - cnt++.
    - On the NUM_WORDS-th word -> CSUM.
  - CSUM: next word compared with sum.
    - Equal -> DONE.
    - Unequal -> ERR, err_code=1.
  - DONE, one cycle:
    - load_done=1.
    - If hold==0, active_bank toggles (this cycle's edge).
    - -> IDLE; load_busy=0.
  - ERR, one cycle: load_err=1; bank unchanged; -> IDLE.
- Write latency: one cycle after the accepted data_valid edge. wr_ram_en is never high outside LOAD-derived cycles.
- A HEADER value inside LOAD/CSUM is data; the parser does not resync.
- Timeout:
  - idle counter runs in ADDR/LOAD/CSUM.
  - Cleared on each data_valid.
  - Reaching TIMEOUT_CYC -> ERR, err_code=2.
  - Counter saturates and does not wrap.
- abort:
  - Priority over data_valid and timeout in the same cycle.
  - In ADDR/LOAD/CSUM -> ERR, err_code=3.
  - In IDLE/DONE/ERR: no effect.
  - A write already registered still issues; no further writes.
- cnt width ADDR_W+1, so NUM_WORDS = 2^ADDR_W does not wrap before the transition.
- Async reset mid-packet: immediate return to reset values. The shadow bank may hold partial data; the active bank is unaffected logically.
- Back-to-back packets: a header on the cycle after DONE/ERR (state IDLE) is accepted.

Decomposition:
- Shared package (wiener_pkg):
  - state enum, HEADER
  - err_code constants (ERR_NONE/CSUM/TMO/ABORT)
  - command bit positions (CMD_RSVD=0, CMD_HOLD=1)
- One sub-module: coef_stream_timeout (saturating idle counter, clear/enable in, expired out).
- Everything else stays in one always block plus the output registers.

Test Plan:
- NUM_WORDS=4, ep_addr=8'h12, raw stream (after swap): C7E5, 1200, 0001, 0002, 0003, 0004, 000A -> 4 writes addr 0..3 data 1..4 on bank 1, load_done pulse, active_bank 0->1, err_code 0.
- Same packet but checksum word 000B -> 4 writes to bank 1, load_err pulse, err_code=1, active_bank stays 0.
- Command word 1202 (hold) with a good checksum -> load_done, active_bank unchanged; a second normal packet then writes bank 1 and swaps.
- Command word 3400 (wrong ep) -> no writes, no pulses, back to IDLE. The next packet with 1200 is accepted.
- TIMEOUT_CYC=10, stop after 2 payload words -> load_err exactly 10 cycles after the last word, err_code=2, no writes after addr 1.
- abort asserted together with data_valid on payload word 3 -> word 3 not written, load_err next cycle, err_code=3. Reset asserted mid-LOAD -> all outputs 0 asynchronously.
